lab62_soc_out_pio: RTL and testbench

Avalon-MM memory-mapped output port for the lab62 SoC. It is the write-side counterpart to the single-bit input PIO slaves that feed status bits to the Nios II. Software writes a data register that drives `out_port`. Software can also fire hardware-timed one-shot pulses on selected bits without CPU polling. It sits on the system interconnect as a slave and drives fabric-side control lines such as resets, enables and strobes.

---
 rtl/lab62_soc_out_pio.sv | 186 ++++++++++++++++++
 tb/tb_lab62_soc_out_pio.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lab62_soc_out_pio.sv
// ---------------------------------------------------------------------------
// lab62_soc_out_pio
//
// Avalon-MM output PIO slave. A data register drives out_port directly, and
// a small pulse engine can invert selected bits for a programmed number of
// cycles without CPU involvement: out_port = data_reg ^ pulse_mask.
//
// Register map (word address):
//   0 DATA     R/W  data register
//   1 PLEN     R/W  pulse length in cycles
//   2 PULSE    W: trigger pulse with mask; R: current pulse mask
//   3 STATUS   R    bit 0 = busy
//   4 OUTSET   W    data |= wdata   (only with OUT_PIO_BITSET_EN)
//   5 OUTCLEAR W    data &= ~wdata  (only with OUT_PIO_BITSET_EN)
//   6,7        reserved
//
// Build option: define OUT_PIO_BITSET_EN to add the OUTSET/OUTCLEAR
// registers; without it addresses 4 and 5 are reserved.
//
// Ports:
//   clk        system clock, rising edge
//   reset      asynchronous, active-high reset
//   chipselect slave select
//   write_n    active-low write strobe
//   address    word address [2:0]
//   writedata  write data [31:0], bits above the register width ignored
//   readdata   registered read data [31:0], zero-extended, 0 when deselected
//   out_port   port output [WIDTH-1:0]
// ---------------------------------------------------------------------------
module lab62_soc_out_pio #(
    parameter int unsigned      WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0,
    parameter int unsigned      PULSE_CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [2:0]       address,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_PLEN   = 3'd1;
    localparam logic [2:0] ADDR_PULSE  = 3'd2;
    localparam logic [2:0] ADDR_STATUS = 3'd3;
`ifdef OUT_PIO_BITSET_EN
    localparam logic [2:0] ADDR_OUTSET = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR = 3'd5;
`else
    // Addresses 4 and 5 decode as reserved in this build.
`endif

    localparam logic [PULSE_CNT_W-1:0] CNT_ONE = PULSE_CNT_W'(1);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [WIDTH-1:0]       data_q, data_d;
    logic [WIDTH-1:0]       mask_q, mask_d;
    logic [PULSE_CNT_W-1:0] plen_q, plen_d;
    logic [PULSE_CNT_W-1:0] count_q, count_d;
    logic [31:0]            readdata_q, readdata_d;

    logic             wr_en;
    logic [WIDTH-1:0] wr_bits;
    logic             trigger;
    logic             last_cycle;
    logic             busy;
    logic             unused_wdata;

    assign wr_en        = chipselect & ~write_n;
    assign wr_bits      = writedata[WIDTH-1:0];
    // Upper writedata bits are intentionally ignored.
    assign unused_wdata = ^writedata;

    // A trigger only counts with a nonzero mask and a nonzero length; the
    // FSM additionally ignores it while a pulse is already running.
    assign trigger    = wr_en && (address == ADDR_PULSE) &&
                        (wr_bits != '0) && (plen_q != '0);
    assign last_cycle = (count_q == CNT_ONE);

    // ---------------- FSM: state register ----------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    // NOTE: every always_comb output gets a default first so no path leaves
    // it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (trigger)    state_d = ST_ACTIVE;
            ST_ACTIVE: if (last_cycle) state_d = ST_IDLE;
            default:                   state_d = ST_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        busy = (state_q == ST_ACTIVE);
    end

    // ---------------- Pulse mask / counter ----------------
    // PULSE writes while ACTIVE fall through untouched: no restart, no merge.
    always_comb begin
        mask_d  = mask_q;
        count_d = count_q;
        if (state_q == ST_IDLE) begin
            if (trigger) begin
                mask_d  = wr_bits;
                count_d = plen_q;
            end
        end else if (last_cycle) begin
            mask_d  = '0;
            count_d = '0;
        end else begin
            count_d = count_q - CNT_ONE;
        end
    end

    // ---------------- Register writes ----------------
    always_comb begin
        data_d = data_q;
        plen_d = plen_q;
        if (wr_en) begin
            case (address)
                ADDR_DATA:   data_d = wr_bits;
                ADDR_PLEN:   plen_d = writedata[PULSE_CNT_W-1:0];
`ifdef OUT_PIO_BITSET_EN
                ADDR_OUTSET: data_d = data_q | wr_bits;
                ADDR_OUTCLR: data_d = data_q & ~wr_bits;
`endif
                default: ;
            endcase
        end
    end

    // ---------------- Read mux ----------------
    // Built from the _q registers, so a read colliding with a write to the
    // same register returns the pre-write value.
    always_comb begin
        readdata_d = '0;
        if (chipselect) begin
            case (address)
                ADDR_DATA:   readdata_d = 32'(data_q);
                ADDR_PLEN:   readdata_d = 32'(plen_q);
                ADDR_PULSE:  readdata_d = 32'(mask_q);
                ADDR_STATUS: readdata_d = {31'b0, busy};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q     <= RESET_VALUE;
            plen_q     <= '0;
            mask_q     <= '0;
            count_q    <= '0;
            readdata_q <= '0;
        end else begin
            data_q     <= data_d;
            plen_q     <= plen_d;
            mask_q     <= mask_d;
            count_q    <= count_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign out_port = data_q ^ mask_q;

endmodule

// File: tb/tb_lab62_soc_out_pio.sv
// ---------------------------------------------------------------------------
// tb_lab62_soc_out_pio
//
// Self-checking bench for lab62_soc_out_pio (WIDTH=8, PULSE_CNT_W=16,
// RESET_VALUE=8'hA5). Directed table, hand-written pulse sequences, then
// randomized bus traffic compared against a time-window reference model.
// ---------------------------------------------------------------------------
module tb_lab62_soc_out_pio;

    logic        clk = 1'b0;
    logic        reset;
    logic        chipselect;
    logic        write_n;
    logic [2:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    int n_checks = 0;
    int n_errors = 0;

    lab62_soc_out_pio #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5),
        .PULSE_CNT_W (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .chipselect (chipselect),
        .write_n    (write_n),
        .address    (address),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_bus(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] wd);
        chipselect = cs;
        write_n    = wn;
        address    = a;
        writedata  = wd;
    endtask

    task automatic bus_idle();
        set_bus(1'b0, 1'b1, 3'd0, 32'h0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] wd);
        set_bus(1'b1, 1'b0, a, wd);
        tick();
        bus_idle();
    endtask

    task automatic rd(input logic [2:0] a);
        set_bus(1'b1, 1'b1, a, 32'h0);
        tick();
        bus_idle();
    endtask

    // ---------------- Reference model ----------------
    // Pulses are modelled as a window of edge numbers: the pulse is visible
    // while the count of elapsed edges is below p_end.
    logic [7:0]  m_data;
    logic [15:0] m_plen;
    logic [7:0]  m_mask;
    logic [31:0] m_rd;
    int unsigned cyc;
    int unsigned p_end;

    function automatic logic [7:0] m_out();
        return m_data ^ ((cyc < p_end) ? m_mask : 8'h00);
    endfunction

    task automatic model_reset();
        m_data = 8'hA5;
        m_plen = 16'h0;
        m_mask = 8'h00;
        m_rd   = 32'h0;
        p_end  = cyc;
    endtask

    // Apply one edge worth of bus activity to the model.
    task automatic model_step(input logic cs, input logic wn, input logic [2:0] a, input logic [31:0] wd);
        bit          busy_pre;
        logic [31:0] rd_pre;
        busy_pre = (cyc < p_end);
        rd_pre   = 32'h0;
        if (cs) begin
            case (a)
                3'd0: rd_pre = {24'h0, m_data};
                3'd1: rd_pre = {16'h0, m_plen};
                3'd2: rd_pre = busy_pre ? {24'h0, m_mask} : 32'h0;
                3'd3: rd_pre = {31'h0, busy_pre};
                default: rd_pre = 32'h0;
            endcase
        end
        if (cs && !wn) begin
            case (a)
                3'd0: m_data = wd[7:0];
                3'd1: m_plen = wd[15:0];
                3'd2: if (!busy_pre && wd[7:0] != 8'h00 && m_plen != 16'h0) begin
                          m_mask = wd[7:0];
                          p_end  = cyc + 1 + int'(m_plen);
                      end
`ifdef OUT_PIO_BITSET_EN
                3'd4: m_data = m_data | wd[7:0];
                3'd5: m_data = m_data & ~wd[7:0];
`endif
                default: ;
            endcase
        end
        cyc++;
        m_rd = rd_pre;
    endtask

    // ---------------- Directed vector table ----------------
    typedef struct {
        logic        cs;
        logic        wn;
        logic [2:0]  addr;
        logic [31:0] wd;
        logic [7:0]  exp_out;
        logic [31:0] exp_rd;
    } vec_t;

    localparam int NV = 20;
    vec_t vecs [NV];

    initial begin
        int n_active;

        // One vector per cycle, expectations sampled after that edge.
        vecs[0]  = '{1'b1, 1'b0, 3'd0, 32'h3C, 8'h3C, 32'hA5}; // DATA=3C, read pre-write value
        vecs[1]  = '{1'b1, 1'b1, 3'd0, 32'h00, 8'h3C, 32'h3C}; // read DATA
        vecs[2]  = '{1'b1, 1'b0, 3'd1, 32'h05, 8'h3C, 32'h00}; // PLEN=5
        vecs[3]  = '{1'b1, 1'b0, 3'd0, 32'h00, 8'h00, 32'h3C}; // DATA=00
        vecs[4]  = '{1'b1, 1'b0, 3'd2, 32'h81, 8'h81, 32'h00}; // PULSE=81, pulse cycle 1
        vecs[5]  = '{1'b1, 1'b1, 3'd3, 32'h00, 8'h81, 32'h01}; // STATUS busy, cycle 2
        vecs[6]  = '{1'b0, 1'b1, 3'd0, 32'h00, 8'h81, 32'h00}; // cycle 3
        vecs[7]  = '{1'b1, 1'b0, 3'd2, 32'h7E, 8'h81, 32'h81}; // PULSE while busy ignored, cycle 4
        vecs[8]  = '{1'b0, 1'b1, 3'd0, 32'h00, 8'h81, 32'h00}; // cycle 5
        vecs[9]  = '{1'b0, 1'b1, 3'd0, 32'h00, 8'h00, 32'h00}; // pulse over
        vecs[10] = '{1'b1, 1'b1, 3'd3, 32'h00, 8'h00, 32'h00}; // STATUS idle
        vecs[11] = '{1'b1, 1'b0, 3'd1, 32'h00, 8'h00, 32'h05}; // PLEN=0
        vecs[12] = '{1'b1, 1'b0, 3'd2, 32'hFF, 8'h00, 32'h00}; // PULSE with PLEN=0 ignored
        vecs[13] = '{1'b1, 1'b1, 3'd3, 32'h00, 8'h00, 32'h00}; // still idle
        vecs[14] = '{1'b1, 1'b0, 3'd1, 32'h03, 8'h00, 32'h00}; // PLEN=3
        vecs[15] = '{1'b1, 1'b0, 3'd2, 32'h00, 8'h00, 32'h00}; // PULSE=0 ignored
        vecs[16] = '{1'b1, 1'b1, 3'd3, 32'h00, 8'h00, 32'h00}; // still idle
        vecs[17] = '{1'b1, 1'b1, 3'd4, 32'h00, 8'h00, 32'h00}; // read addr 4 -> 0
        vecs[18] = '{1'b1, 1'b1, 3'd6, 32'h00, 8'h00, 32'h00}; // reserved read -> 0
        vecs[19] = '{1'b1, 1'b0, 3'd3, 32'hFF, 8'h00, 32'h00}; // STATUS write ignored

        reset = 1'b0;
        bus_idle();
        cyc = 0;
        tick();
        tick();

        // Asynchronous reset asserted mid-cycle takes effect immediately.
        reset = 1'b1;
        #2;
        check("reset_out_async", {24'h0, out_port}, 32'hA5);
        check("reset_rd_async", readdata, 32'h0);
        tick();
        check("reset_out_held", {24'h0, out_port}, 32'hA5);
        reset = 1'b0;

        for (int i = 0; i < NV; i++) begin
            set_bus(vecs[i].cs, vecs[i].wn, vecs[i].addr, vecs[i].wd);
            tick();
            check($sformatf("vec%0d_out", i), {24'h0, out_port}, {24'h0, vecs[i].exp_out});
            check($sformatf("vec%0d_rd", i), readdata, vecs[i].exp_rd);
        end
        bus_idle();
        tick();

        // DATA write mid-pulse: PLEN=10, PULSE=0F, DATA=F0 on the 4th pulse edge.
        wr(3'd1, 32'd10);
        wr(3'd2, 32'h0F);
        check("dwp_start", {24'h0, out_port}, 32'h0F);
        tick();
        tick();
        check("dwp_pre_write", {24'h0, out_port}, 32'h0F);
        wr(3'd0, 32'hF0);
        check("dwp_after_write", {24'h0, out_port}, 32'hFF);
        for (int k = 0; k < 6; k++) tick();
        check("dwp_last_pulse_cycle", {24'h0, out_port}, 32'hFF);
        tick();
        check("dwp_end", {24'h0, out_port}, 32'hF0);

        // DATA write on the terminating edge: both take effect.
        wr(3'd1, 32'd2);
        wr(3'd2, 32'h01);
        check("term_start", {24'h0, out_port}, 32'hF1);
        tick();
        check("term_mid", {24'h0, out_port}, 32'hF1);
        wr(3'd0, 32'h55);
        check("term_edge", {24'h0, out_port}, 32'h55);
        rd(3'd3);
        check("term_status", readdata, 32'h0);

        // Bitset registers.
        wr(3'd0, 32'h0F);
        wr(3'd4, 32'h30);
`ifdef OUT_PIO_BITSET_EN
        check("outset", {24'h0, out_port}, 32'h3F);
`else
        check("outset", {24'h0, out_port}, 32'h0F);
`endif
        wr(3'd5, 32'h01);
`ifdef OUT_PIO_BITSET_EN
        check("outclear", {24'h0, out_port}, 32'h3E);
`else
        check("outclear", {24'h0, out_port}, 32'h0F);
`endif
        rd(3'd4);
        check("read_addr4", readdata, 32'h0);
        rd(3'd5);
        check("read_addr5", readdata, 32'h0);

        // Reset mid-pulse, then a fresh pulse must run the full length.
        wr(3'd0, 32'h00);
        wr(3'd1, 32'd100);
        wr(3'd2, 32'hFF);
        for (int k = 0; k < 19; k++) tick();
        check("rmp_before_reset", {24'h0, out_port}, 32'hFF);
        reset = 1'b1;
        #2;
        check("rmp_reset_out", {24'h0, out_port}, 32'hA5);
        #1;
        reset = 1'b0;
        rd(3'd3);
        check("rmp_status", readdata, 32'h0);
        rd(3'd1);
        check("rmp_plen_cleared", readdata, 32'h0);
        wr(3'd1, 32'd100);
        wr(3'd2, 32'hFF);
        n_active = 0;
        for (int k = 0; k < 200; k++) begin
            if (out_port !== 8'h5A) break;
            n_active++;
            tick();
        end
        check("rmp_new_pulse_len", n_active, 32'd100);
        check("rmp_new_pulse_end", {24'h0, out_port}, 32'hA5);

        // Randomized traffic against the reference model.
        reset = 1'b1;
        #2;
        reset = 1'b0;
        model_reset();
        for (int i = 0; i < 3000; i++) begin
            logic        cs;
            logic        wn;
            logic [2:0]  a;
            logic [31:0] wd;
            if ($urandom_range(0, 399) == 0) begin
                reset = 1'b1;
                #2;
                model_reset();
                check("rand_reset_out", {24'h0, out_port}, {24'h0, m_out()});
                check("rand_reset_rd", readdata, m_rd);
                reset = 1'b0;
            end
            cs = ($urandom_range(0, 3) != 0);
            wn = $urandom_range(0, 1) == 1;
            a  = 3'($urandom_range(0, 7));
            wd = $urandom;
            if (a == 3'd1) wd = $urandom_range(0, 12);
            if (a == 3'd2 && $urandom_range(0, 7) == 0) wd = 32'h0;
            set_bus(cs, wn, a, wd);
            model_step(cs, wn, a, wd);
            tick();
            check("rand_out", {24'h0, out_port}, {24'h0, m_out()});
            check("rand_rd", readdata, m_rd);
        end
        bus_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
